// File: rtl/conv3x3_stream_engine.sv
// Streaming 3x3 valid-mode convolution over a raster-order image: NUM_CH output channels,
// each with its own kernel and bias, followed by shift, optional ReLU and saturation.
module conv3x3_stream_engine #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IMG_WIDTH  = 28,
    parameter int unsigned IMG_HEIGHT = 28,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned ACC_WIDTH  = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         cfg_we_i,
    input  logic [7:0]                   cfg_addr_i,
    input  logic [31:0]                  cfg_wdata_i,
    input  logic                         start_i,
    output logic                         busy_o,
    output logic                         done_o,
    input  logic                         pix_valid_i,
    output logic                         pix_ready_o,
    input  logic [DATA_WIDTH-1:0]        pix_data_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [NUM_CH*DATA_WIDTH-1:0] out_data_o,
    output logic                         out_last_o
);
    localparam int unsigned COL_W = $clog2(IMG_WIDTH);
    localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StFlush = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    logic [1:0]                   state_q, state_d;
    logic [COL_W-1:0]             col_q;
    logic [ROW_W-1:0]             row_q;
    logic                         relu_en_q;
    logic [3:0]                   shift_q;
    logic signed [DATA_WIDTH-1:0] weight_q [NUM_CH][9];
    logic signed [ACC_WIDTH-1:0]  bias_q [NUM_CH];
    logic [DATA_WIDTH-1:0]        lb_top_q [IMG_WIDTH];
    logic [DATA_WIDTH-1:0]        lb_mid_q [IMG_WIDTH];
    logic [DATA_WIDTH-1:0]        win_q [9];
    logic [DATA_WIDTH-1:0]        win_d [9];
    logic                         out_valid_q, out_last_q;
    logic [NUM_CH*DATA_WIDTH-1:0] out_data_q, result;
    logic signed [ACC_WIDTH-1:0]  acc, shifted;
    logic                         pix_acc, out_hs, emit, col_last, row_last;

    assign busy_o      = state_q != StIdle;
    assign done_o      = state_q == StDone;
    assign pix_ready_o = (state_q == StRun) && (!out_valid_q || out_ready_i);
    assign pix_acc     = pix_valid_i && pix_ready_o;
    assign out_hs      = out_valid_q && out_ready_i;
    assign col_last    = col_q == COL_W'(IMG_WIDTH - 1);
    assign row_last    = row_q == ROW_W'(IMG_HEIGHT - 1);
    assign emit        = pix_acc && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start_i) state_d = StRun;
            StRun:   if (pix_acc && row_last && col_last) state_d = StFlush;
            StFlush: if (out_hs && out_last_q) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Window as it will look after the current pixel is shifted in; k = row*3 + col.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_d[r*3]   = win_q[r*3+1];
            win_d[r*3+1] = win_q[r*3+2];
        end
        win_d[2] = lb_top_q[col_q];
        win_d[5] = lb_mid_q[col_q];
        win_d[8] = pix_data_i;
        result   = '0;
        acc      = '0;
        shifted  = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            acc = bias_q[ch];
            for (int k = 0; k < 9; k++) begin
                acc = acc + ACC_WIDTH'({1'b0, win_d[k]}) * ACC_WIDTH'(weight_q[ch][k]);
            end
            shifted = acc >>> shift_q;
            if (relu_en_q && shifted[ACC_WIDTH-1]) shifted = '0;
            if (shifted > SAT_MAX) shifted = SAT_MAX;
            else if (shifted < SAT_MIN) shifted = SAT_MIN;
            result[ch*DATA_WIDTH +: DATA_WIDTH] = shifted[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            for (int k = 0; k < 9; k++) win_q[k] <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && start_i) begin
                col_q <= '0;
                row_q <= '0;
            end else if (pix_acc) begin
                for (int k = 0; k < 9; k++) win_q[k] <= win_d[k];
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_last ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
            // An accepted pixel implies any pending output is being consumed this cycle.
            if (emit) begin
                out_valid_q <= 1'b1;
                out_data_q  <= result;
                out_last_q  <= row_last && col_last;
            end else if (out_hs) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (pix_acc) begin
            lb_top_q[col_q] <= lb_mid_q[col_q];
            lb_mid_q[col_q] <= pix_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            relu_en_q <= 1'b0;
            shift_q   <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                bias_q[ch] <= '0;
                for (int k = 0; k < 9; k++) weight_q[ch][k] <= '0;
            end
        end else if (cfg_we_i && !busy_o) begin
            if (cfg_addr_i == 8'h00) begin
                relu_en_q <= cfg_wdata_i[0];
                shift_q   <= cfg_wdata_i[11:8];
            end
            for (int ch = 0; ch < NUM_CH; ch++) begin
                for (int k = 0; k < 9; k++) begin
                    if (cfg_addr_i == 8'(16 + 4 * (ch * 9 + k))) begin
                        weight_q[ch][k] <= cfg_wdata_i[DATA_WIDTH-1:0];
                    end
                end
                if (cfg_addr_i == 8'(128 + 4 * ch)) begin
                    bias_q[ch] <= ACC_WIDTH'($signed(cfg_wdata_i));
                end
            end
        end
    end

endmodule
